// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t     : FSM encoding used by dmem_responder
//   BYTE_W      : bits per byte lane
//   lane_count  : number of byte lanes for a given data width
//   word_index  : byte address -> word index (full width, range-checked by caller)
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int BYTE_W         = 8;
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_LANES  = DEFAULT_DATA_W / BYTE_W;

   function automatic int lane_count(input int data_w);
      return data_w / BYTE_W;
   endfunction

   // Kept at full width so the out-of-range compare sees every address bit;
   // only after that compare passes are the low index bits used.
   function automatic logic [63:0] word_index(input logic [63:0] byte_addr,
                                              input int          off_w);
      return byte_addr >> off_w;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous DEPTH x DATA_W word storage.
//   clk    : rising-edge clock
//   we     : write strobe, lanes selected by be
//   re     : read strobe, rdata updates on the same edge and holds otherwise
//   addr   : word index shared by read and write
//   be     : byte-lane enables for writes
//   wdata  : write data
//   rdata  : registered read data (not reset; the responder masks it)
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int LANES  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  addr,
   input  logic [LANES-1:0]  be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int l = 0; l < LANES; l++) begin
            if (be[l]) begin
               mem[addr][l*8 +: 8] <= wdata[l*8 +: 8];
            end
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: word-addressed RAM behind a valid/ready request/response
// handshake with WAIT_CYCLES wait states, one transaction in flight.
//   clk, rst_n                     : clock, async active-low reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_write/addr/wdata/be        : request payload, latched on acceptance
//   resp_valid/resp_ready          : response handshake, valid held until taken
//   resp_rdata                     : load data; 0 for stores and errors
//   resp_err                       : misaligned or out-of-range access
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a request; accepts on req_valid
// ST_WAIT | counting wait states; access performed on the edge leaving it
// ST_RESP | response presented until resp_ready
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   input  logic [DATA_W/8-1:0]       req_be,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      resp_err
);

   localparam int LANES     = lane_count(DATA_W);
   localparam int OFF_W     = $clog2(LANES);
   localparam int IDX_W     = $clog2(DEPTH);
   localparam int CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [LANES-1:0]    be_q;
   logic                err_q;
   logic                rsel_q;

   logic                accept;
   logic                do_access;
   logic                cur_write;
   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_wdata;
   logic [LANES-1:0]    cur_be;
   logic [63:0]         word_full;
   logic                addr_err;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   arr_rdata;

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign accept     = req_ready & req_valid;

   // With zero wait states the access happens on the accepting edge, before
   // the latches hold anything, so the live request feeds the array then.
   assign cur_write = (state_q == ST_IDLE) ? req_write : write_q;
   assign cur_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
   assign cur_be    = (state_q == ST_IDLE) ? req_be    : be_q;

   assign word_full = word_index(64'(cur_addr), OFF_W);
   assign addr_err  = (cur_addr[OFF_W-1:0] != '0) || (word_full >= 64'(DEPTH));
   assign idx       = word_full[IDX_W-1:0];

   assign do_access = (ZERO_WAIT && accept) ||
                      ((state_q == ST_WAIT) && (cnt_q <= CNT_ONE));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ZERO_WAIT ? ST_RESP : ST_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_WAIT: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = ST_RESP;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         err_q   <= 1'b0;
         rsel_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
         if (do_access) begin
            err_q  <= addr_err;
            rsel_q <= ~cur_write & ~addr_err;
         end else if ((state_q == ST_RESP) && resp_ready) begin
            err_q  <= 1'b0;
            rsel_q <= 1'b0;
         end
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .LANES  (LANES)
   ) u_array (
      .clk   (clk),
      .we    (do_access & cur_write & ~addr_err),
      .re    (do_access & ~cur_write & ~addr_err),
      .addr  (idx),
      .be    (cur_be),
      .wdata (cur_wdata),
      .rdata (arr_rdata)
   );

   // The array read register is not reset and holds stale data, so only a
   // successful load lets it reach the port.
   assign resp_rdata = rsel_q ? arr_rdata : '0;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int W     = 2;
   localparam int DEPTH = 256;
   localparam int NUSED = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid, req_write, resp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid0, req_write0, resp_ready0;
   logic [31:0] req_addr0, req_wdata0;
   logic [3:0]  req_be0;
   logic        req_ready0, resp_valid0, resp_err0;
   logic [31:0] resp_rdata0;

   dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err));

   dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0),
      .resp_rdata(resp_rdata0), .resp_err(resp_err0));

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   int          acc_q[$];
   logic [31:0] model_mem [DEPTH];
   int          used_w [NUSED];
   int          hold_cnt = 0;
   int          tcnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference: word RAM with byte lanes; bad address = no effect, err=1.
   function automatic exp_t model_access(input bit wr, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic [3:0] be);
      exp_t e;
      e.err   = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
      e.rdata = 32'h0;
      if (!e.err) begin
         if (wr) begin
            for (int l = 0; l < 4; l++) begin
               if (be[l]) model_mem[addr/4][8*l +: 8] = wd[8*l +: 8];
            end
         end else begin
            e.rdata = model_mem[addr/4];
         end
      end
      return e;
   endfunction

   // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
   task automatic do_req(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
      bit done = 0;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (req_ready) begin
            done = 1;
            exp_q.push_back(model_access(wr, addr, wd, be));
         end
      end
      if (!done) fail_now("req_accept_timeout");
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout");
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   // Monitor / scoreboard for the WAIT_CYCLES=2 instance.
   initial begin : monitor
      bit          prev_stall = 0, prev_hs = 0, seen_valid = 0;
      logic [31:0] prev_rdata = 0;
      logic        prev_err = 0;
      exp_t        e;
      resp_ready = 1'b1;
      forever begin
         @(negedge clk);
         tcnt++;
         if (!rst_n) begin
            acc_q.delete();
            exp_q.delete();
            prev_stall = 0;
            prev_hs    = 0;
            seen_valid = 0;
         end else begin
            if (resp_valid && hold_cnt > 0) begin
               resp_ready = 1'b0;
               hold_cnt--;
            end else begin
               resp_ready = ($urandom_range(0, 3) != 0);
            end
            if (prev_hs) chk("req_ready_after_resp", req_ready, 1);
            if (prev_stall) begin
               chk("stall_valid", resp_valid, 1);
               chk("stall_rdata", resp_rdata, prev_rdata);
               chk("stall_err", resp_err, prev_err);
            end
            if (resp_valid) begin
               chk("req_ready_in_resp", req_ready, 0);
               if (!seen_valid) begin
                  seen_valid = 1;
                  if (acc_q.size() == 0) fail_now("latency_no_accept");
                  else chk("latency", 64'(tcnt - acc_q.pop_front()), W + 1);
               end
               if (resp_ready) begin
                  seen_valid = 0;
                  if (exp_q.size() == 0) fail_now("unexpected_response");
                  else begin
                     e = exp_q.pop_front();
                     chk("resp_rdata", resp_rdata, e.rdata);
                     chk("resp_err", resp_err, e.err);
                  end
               end
            end
            prev_hs    = resp_valid && resp_ready;
            prev_stall = resp_valid && !resp_ready;
            prev_rdata = resp_rdata;
            prev_err   = resp_err;
            if (req_valid && req_ready) acc_q.push_back(tcnt);
         end
      end
   end

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog_timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] a, d0 [4];
      int          r, idx, nresp, last_acc;
      int          acc0[$];
      bit          wr;

      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      for (int i = 0; i < 16; i++) used_w[i] = i;
      used_w[16] = 254;
      used_w[17] = 255;

      rst_n = 1'b0;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0;
      req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0;
      resp_ready0 = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", req_ready, 1);
      chk("reset_resp_valid", resp_valid, 0);
      chk("reset_resp_rdata", resp_rdata, 0);
      chk("reset_resp_err", resp_err, 0);
      chk("reset0_req_ready", req_ready0, 1);
      chk("reset0_resp_valid", resp_valid0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NUSED; i++) do_req(1, 32'(used_w[i] * 4), $urandom, 4'hF);

      do_req(1, 32'h10, 32'hDEADBEEF, 4'hF);
      do_req(0, 32'h10, $urandom, 4'h0);
      do_req(1, 32'h10, 32'h000000AA, 4'h1);
      do_req(0, 32'h10, $urandom, 4'hF);

      do_req(0, 32'h13, $urandom, 4'hF);
      do_req(0, 32'h400, $urandom, 4'hF);
      do_req(1, 32'h400, 32'h55555555, 4'hF);
      do_req(0, 32'h0, 0, 4'h0);
      do_req(1, 32'h14, 32'hFFFFFFFF, 4'h0);
      do_req(0, 32'h14, 0, 4'h0);

      wait_idle();
      hold_cnt = 5;
      do_req(0, 32'h10, 0, 4'h0);
      wait_idle();

      // Abort a store in WAIT; it must never reach the RAM.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
      req_wdata = 32'h12345678; req_be = 4'hF;
      @(negedge clk);
      chk("abort_req_ready", req_ready, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_resp_valid", resp_valid, 0);
      chk("midrst_resp_err", resp_err, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_req_ready", req_ready, 1);
      chk("postrst_resp_valid", resp_valid, 0);
      @(posedge clk); #1;
      do_req(0, 32'h10, 0, 4'h0);

      repeat (150) begin
         a = 32'(used_w[$urandom_range(0, NUSED - 1)] * 4);
         r = $urandom_range(0, 9);
         if (r == 7) a = a | 32'($urandom_range(1, 3));
         else if (r == 8) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
         else if (r == 9) a = $urandom | 32'h8000_0000;
         wr = 1'($urandom);
         do_req(wr, a, $urandom, 4'($urandom));
      end

      for (int i = 0; i < NUSED; i++) do_req(0, 32'(used_w[i] * 4), $urandom, 4'h0);
      wait_idle();

      // Zero-wait instance: 4 stores then 4 loads, request held high.
      for (int i = 0; i < 4; i++) d0[i] = $urandom;
      idx = 0; nresp = 0; last_acc = -100;
      req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 0; req_wdata0 = d0[0]; req_be0 = 4'hF;
      for (int t = 0; t < 80 && nresp < 8; t++) begin
         @(negedge clk);
         if (resp_valid0) begin
            if (acc0.size() == 0) fail_now("w0_resp_no_accept");
            else chk("w0_latency", 64'(t - acc0.pop_front()), 1);
            chk("w0_rdata", resp_rdata0, (nresp < 4) ? 32'h0 : d0[nresp - 4]);
            chk("w0_err", resp_err0, 0);
            nresp++;
         end
         if (req_valid0 && req_ready0) begin
            acc0.push_back(t);
            if (idx > 0) chk("w0_interval", 64'(t - last_acc), 2);
            last_acc = t;
            idx++;
         end
         @(posedge clk); #1;
         if (idx < 8) begin
            req_write0 = (idx < 4);
            req_addr0  = 32'((idx % 4) * 4);
            req_wdata0 = d0[idx % 4];
         end else begin
            req_valid0 = 1'b0;
         end
      end
      if (nresp < 8) fail_now("w0_response_timeout");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
